// File: rtl/cellrv32_gpio_irq_if.sv
// Processor IO bus seen by the GPIO interrupt detector.
// Word-wide single-cycle read/write strobes with a registered acknowledge.
interface cellrv32_gpio_irq_if;
  logic [31:0] addr;
  logic        rden;
  logic        wren;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ack;

  modport master (output addr, rden, wren, wdata, input rdata, ack);
  modport slave  (input addr, rden, wren, wdata, output rdata, ack);
endinterface

// File: rtl/cellrv32_gpio_irq.sv
// Per-pin GPIO interrupt detector: edge/level events latched into PEND, one level IRQ.
// Optional input debounce filter built in with `define CELLRV32_GPIO_IRQ_DEBOUNCE_EN.
module cellrv32_gpio_irq_pin (
  input  logic clk_i,
  input  logic rst_i,
  input  logic cur_i,
  input  logic prev_i,
  input  logic en_i,
  input  logic typ_i,
  input  logic pol_i,
  input  logic clr_i,
  output logic pend_o
);
  logic pend_q, pend_d, det;

  always_comb begin
    if (typ_i) det = pol_i ? (!prev_i & cur_i) : (prev_i & !cur_i);
    else       det = (cur_i == pol_i);
    // set wins over a same-cycle clear
    pend_d = (pend_q & ~clr_i) | (det & en_i);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) pend_q <= 1'b0;
    else       pend_q <= pend_d;
  end

  assign pend_o = pend_q;
endmodule

module cellrv32_gpio_irq #(
  parameter int          GPIO_NUM  = 64,
  parameter logic [31:0] BASE_ADDR = 32'hFFFFFC20
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  cellrv32_gpio_irq_if.slave     bus,
  input  logic [63:0]            gpio_i,
  output logic                   irq_o
);
  localparam logic [63:0] VMASK = (GPIO_NUM >= 64) ? {64{1'b1}} :
                                  ((64'd1 << GPIO_NUM) - 64'd1);

  logic [63:0] sync_q, sync_d, prev_q, prev_d, cur;
  logic [63:0] en_q, en_d, type_q, type_d, pol_q, pol_d;
  logic [63:0] pend, clr, wmask, wval, rsel;
  logic [31:0] rdata_q, rdata_d;
  logic        ack_q, ack_d, irq_q, irq_d;
  logic        acc_en, wr, rd;
  logic [2:0]  wsel;
  logic        unused_addr;

  assign acc_en      = (bus.addr[31:5] == BASE_ADDR[31:5]);
  assign wr          = bus.wren & acc_en;
  assign rd          = bus.rden & acc_en;
  assign wsel        = bus.addr[4:2];
  assign unused_addr = ^bus.addr[1:0];

`ifdef CELLRV32_GPIO_IRQ_DEBOUNCE_EN
  logic [15:0]      presc_q, presc_d;
  logic [63:0][2:0] sh_q, sh_d;
  logic [63:0]      filt_q, filt_d;
  logic             tick;

  always_comb begin
    tick    = (presc_q == 16'hFFFF);
    presc_d = presc_q + 16'd1;
    sh_d    = sh_q;
    filt_d  = filt_q;
    for (int i = 0; i < 64; i++) begin
      if (tick) sh_d[i] = {sh_q[i][1:0], sync_q[i]};
      // only a unanimous sample window may flip the filtered pin
      if (sh_q[i] == 3'b111)      filt_d[i] = 1'b1;
      else if (sh_q[i] == 3'b000) filt_d[i] = 1'b0;
    end
  end
  assign cur = filt_q;
`else
  assign cur = sync_q;
`endif

  always_comb begin
    sync_d = gpio_i;
    prev_d = cur;
    wmask  = wsel[0] ? {32'hFFFFFFFF, 32'h0} : {32'h0, 32'hFFFFFFFF};
    wmask  = wmask & VMASK;
    wval   = {bus.wdata, bus.wdata} & wmask;
    en_d   = en_q;
    type_d = type_q;
    pol_d  = pol_q;
    clr    = '0;
    if (wr) begin
      case (wsel[2:1])
        2'd0:    en_d   = (en_q   & ~wmask) | wval;
        2'd1:    type_d = (type_q & ~wmask) | wval;
        2'd2:    pol_d  = (pol_q  & ~wmask) | wval;
        default: clr    = wval;
      endcase
    end
    case (wsel[2:1])
      2'd0:    rsel = en_q;
      2'd1:    rsel = type_q;
      2'd2:    rsel = pol_q;
      default: rsel = pend;
    endcase
    rdata_d = rd ? (wsel[0] ? rsel[63:32] : rsel[31:0]) : 32'h0;
    ack_d   = (bus.rden | bus.wren) & acc_en;
    // a disabled pin keeps its stale pending bit but cannot raise the IRQ
    irq_d   = |(pend & en_q);
  end

  cellrv32_gpio_irq_pin u_pin [63:0] (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .cur_i  (cur),
    .prev_i (prev_q),
    .en_i   (en_q),
    .typ_i  (type_q),
    .pol_i  (pol_q),
    .clr_i  (clr),
    .pend_o (pend)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q  <= '0;
      prev_q  <= '0;
      en_q    <= '0;
      type_q  <= '0;
      pol_q   <= '0;
      rdata_q <= '0;
      ack_q   <= 1'b0;
      irq_q   <= 1'b0;
`ifdef CELLRV32_GPIO_IRQ_DEBOUNCE_EN
      presc_q <= '0;
      sh_q    <= '0;
      filt_q  <= '0;
`endif
    end else begin
      sync_q  <= sync_d;
      prev_q  <= prev_d;
      en_q    <= en_d;
      type_q  <= type_d;
      pol_q   <= pol_d;
      rdata_q <= rdata_d;
      ack_q   <= ack_d;
      irq_q   <= irq_d;
`ifdef CELLRV32_GPIO_IRQ_DEBOUNCE_EN
      presc_q <= presc_d;
      sh_q    <= sh_d;
      filt_q  <= filt_d;
`endif
    end
  end

  assign bus.rdata = rdata_q;
  assign bus.ack   = ack_q;
  assign irq_o     = irq_q;
endmodule

// File: tb/tb_cellrv32_gpio_irq.sv
// Directed bench for cellrv32_gpio_irq: a 64-pin instance and an 8-pin instance
// on one clock, checked with immediate assertions against hand-computed values.
module tb_cellrv32_gpio_irq;
  localparam logic [31:0] BA = 32'hFFFFFC20;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic [63:0] gpio_a = '0, gpio_b = '0;
  logic        irq_a, irq_b;
  int          checks = 0, failures = 0;

  cellrv32_gpio_irq_if bus_a ();
  cellrv32_gpio_irq_if bus_b ();

  cellrv32_gpio_irq #(.GPIO_NUM(64), .BASE_ADDR(BA)) dut_a (
    .clk_i(clk_i), .rst_i(rst_i), .bus(bus_a.slave), .gpio_i(gpio_a), .irq_o(irq_a));
  cellrv32_gpio_irq #(.GPIO_NUM(8), .BASE_ADDR(BA)) dut_b (
    .clk_i(clk_i), .rst_i(rst_i), .bus(bus_b.slave), .gpio_i(gpio_b), .irq_o(irq_b));

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) @(negedge clk_i);
  endtask

  task automatic bus_wr(input bit b, input logic [31:0] a, input logic [31:0] d);
    if (!b) begin bus_a.addr = a; bus_a.wdata = d; bus_a.wren = 1'b1; end
    else    begin bus_b.addr = a; bus_b.wdata = d; bus_b.wren = 1'b1; end
    @(negedge clk_i);
    bus_a.wren = 1'b0; bus_b.wren = 1'b0;
    check("wr_ack", {31'h0, b ? bus_b.ack : bus_a.ack}, 32'h1);
  endtask

  task automatic bus_rd(input bit b, input logic [31:0] a, input logic [31:0] exp,
                        input string tag, input logic exp_ack = 1'b1);
    if (!b) begin bus_a.addr = a; bus_a.rden = 1'b1; end
    else    begin bus_b.addr = a; bus_b.rden = 1'b1; end
    @(negedge clk_i);
    bus_a.rden = 1'b0; bus_b.rden = 1'b0;
    check({tag, "_ack"}, {31'h0, b ? bus_b.ack : bus_a.ack}, {31'h0, exp_ack});
    check(tag, b ? bus_b.rdata : bus_a.rdata, exp);
    // read data is a single-cycle pulse
    @(negedge clk_i);
    check({tag, "_clr"}, b ? bus_b.rdata : bus_a.rdata, 32'h0);
  endtask

  initial begin
    bus_a.addr = '0; bus_a.rden = 1'b0; bus_a.wren = 1'b0; bus_a.wdata = '0;
    bus_b.addr = '0; bus_b.rden = 1'b0; bus_b.wren = 1'b0; bus_b.wdata = '0;
    tick(3);
    rst_i = 1'b0;

    // reset state
    check("rst_irq", {31'h0, irq_a}, 32'h0);
    check("rst_ack", {31'h0, bus_a.ack}, 32'h0);
    for (int r = 0; r < 8; r++) bus_rd(0, BA + 32'(r * 4), 32'h0, "rst_reg");
    bus_rd(0, 32'hFFFFFC40, 32'h0, "miss", 1'b0);

    // rising edge on pin 0
    bus_wr(0, BA + 32'h08, 32'h1);
    bus_wr(0, BA + 32'h10, 32'h1);
    bus_wr(0, BA + 32'h00, 32'h1);
    gpio_a[0] = 1'b1;
    tick(1); check("edge_irq_k",  {31'h0, irq_a}, 32'h0);
    tick(1); check("edge_irq_k1", {31'h0, irq_a}, 32'h0);
    tick(1); check("edge_irq_k2", {31'h0, irq_a}, 32'h1);
    bus_rd(0, BA + 32'h18, 32'h1, "edge_pend");
    bus_wr(0, BA + 32'h18, 32'h1);
    check("w1c_irq_same", {31'h0, irq_a}, 32'h1);
    tick(1); check("w1c_irq_next", {31'h0, irq_a}, 32'h0);
    bus_rd(0, BA + 32'h18, 32'h0, "w1c_pend");

    // low level on pin 63
    bus_wr(0, BA + 32'h04, 32'h8000_0000);
    tick(1);
    bus_rd(0, BA + 32'h1C, 32'h8000_0000, "lvl_pend");
    bus_wr(0, BA + 32'h1C, 32'h8000_0000);
    bus_rd(0, BA + 32'h1C, 32'h8000_0000, "lvl_repend");
    gpio_a[63] = 1'b1;
    tick(2);
    bus_wr(0, BA + 32'h1C, 32'h8000_0000);
    bus_rd(0, BA + 32'h1C, 32'h0, "lvl_cleared");
    check("lvl_irq_off", {31'h0, irq_a}, 32'h0);

    // falling edge on pin 5 coincident with its W1C
    bus_wr(0, BA + 32'h08, 32'h21);
    bus_wr(0, BA + 32'h10, 32'h01);
    bus_wr(0, BA + 32'h00, 32'h21);
    gpio_a[5] = 1'b1;
    tick(2);
    bus_wr(0, BA + 32'h18, 32'h21);
    bus_rd(0, BA + 32'h18, 32'h0, "fall_pre");
    gpio_a[5] = 1'b0;
    tick(1);
    bus_wr(0, BA + 32'h18, 32'h20);
    bus_rd(0, BA + 32'h18, 32'h20, "fall_set_wins");
    bus_wr(0, BA + 32'h18, 32'h20);
    bus_rd(0, BA + 32'h18, 32'h0, "fall_clr");

    // 8-pin instance: upper pins inert
    bus_wr(1, BA + 32'h08, 32'hFFFF_FFFF);
    bus_wr(1, BA + 32'h10, 32'hFFFF_FFFF);
    bus_wr(1, BA + 32'h00, 32'hFFFF_FFFF);
    bus_rd(1, BA + 32'h00, 32'h0000_00FF, "n8_en");
    bus_wr(1, BA + 32'h04, 32'hFFFF_FFFF);
    bus_rd(1, BA + 32'h04, 32'h0, "n8_en_hi");
    gpio_b[12] = 1'b1;
    tick(3);
    bus_rd(1, BA + 32'h18, 32'h0, "n8_pin12");
    check("n8_irq_off", {31'h0, irq_b}, 32'h0);
    gpio_b[3] = 1'b1;
    tick(3);
    bus_rd(1, BA + 32'h18, 32'h8, "n8_pin3");
    check("n8_irq_on", {31'h0, irq_b}, 32'h1);

    // reset mid-operation: pin 63 low-level source pending
    bus_wr(0, BA + 32'h00, 32'h0);
    bus_wr(0, BA + 32'h04, 32'h8000_0000);
    gpio_a[63] = 1'b0;
    tick(4);
    check("pre_rst_irq", {31'h0, irq_a}, 32'h1);
    rst_i = 1'b1;
    tick(1);
    rst_i = 1'b0;
    check("mid_rst_irq", {31'h0, irq_a}, 32'h0);
    tick(2);
    bus_rd(0, BA + 32'h1C, 32'h0, "mid_rst_pend");
    bus_rd(0, BA + 32'h04, 32'h0, "mid_rst_en");
    check("mid_rst_irq2", {31'h0, irq_a}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
